// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiply/accumulate unit.
package mult_pkg;

    // Control FSM states
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mult_state_e;

    // Booth digit encoding, bit layout is {neg, two, zero}
    typedef enum logic [2:0] {
        DigitP1   = 3'b000,
        DigitZero = 3'b001,
        DigitP2   = 3'b010,
        DigitM1   = 3'b100,
        DigitM2   = 3'b110
    } booth_digit_e;

    // Radix-4 iterations needed for an operand of the given (even) width after
    // extension by two bits.
    function automatic int unsigned iter_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to digit select lines.
module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0] window_i,
    output logic       neg_o,
    output logic       two_o,
    output logic       zero_o
);

    booth_digit_e digit;

    // Map window {b[i+1], b[i], b[i-1]} to a digit in {0, +-1, +-2}
    always_comb begin
        digit = DigitZero;
        unique case (window_i)
            3'b000, 3'b111: digit = DigitZero;
            3'b001, 3'b010: digit = DigitP1;
            3'b011:         digit = DigitP2;
            3'b100:         digit = DigitM2;
            3'b101, 3'b110: digit = DigitM1;
            default:        digit = DigitZero;
        endcase
        {neg_o, two_o, zero_o} = digit;
    end

endmodule

// File: rtl/booth_r4_mult_acc.sv
// Sequential radix-4 Booth multiplier with optional accumulate into the
// product register. start/busy/done handshake, nb/2+1 iterations per result.
module booth_r4_mult_acc
    import mult_pkg::*;
#(
    parameter int unsigned nb = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_mode,
    input  logic            acc_en,
    input  logic [nb-1:0]   A,
    input  logic [nb-1:0]   B,
    output logic            busy,
    output logic            done,
    output logic [2*nb-1:0] product
);

    localparam int unsigned N    = iter_count(nb);
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    mult_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [nb+1:0]   mcand_q, mcand_d;   // extended multiplicand
    logic [nb+2:0]   hi_q, hi_d;         // upper accumulator slice
    logic [nb+1:0]   lo_q, lo_d;         // extended multiplier, low product bits shift in
    logic            xb_q, xb_d;         // implicit bit below the current window
    logic            acc_en_q, acc_en_d;
    logic            done_q, done_d;
    logic [2*nb-1:0] product_q, product_d;

    logic            neg, two, zero;
    logic [nb+2:0]   mcand_x, mag, addend, sum_hi;
    logic [nb+2:0]   hi_nxt;
    logic [nb+1:0]   lo_nxt;
    logic            xb_nxt;
    logic [2*nb+4:0] prod_full;
    logic [2*nb-1:0] sum_low;
    logic            unused_prod;

    booth_r4_enc u_enc (
        .window_i ({lo_q[1:0], xb_q}),
        .neg_o    (neg),
        .two_o    (two),
        .zero_o   (zero)
    );

    // One iteration: add the selected multiple to the upper slice, then shift right by two
    always_comb begin
        mcand_x   = {mcand_q[nb+1], mcand_q};
        mag       = zero ? '0 : (two ? {mcand_q, 1'b0} : mcand_x);
        addend    = neg ? ~mag : mag;
        sum_hi    = hi_q + addend + {{(nb+2){1'b0}}, neg};
        hi_nxt    = {{2{sum_hi[nb+2]}}, sum_hi[nb+2:2]};
        lo_nxt    = {sum_hi[1:0], lo_q[nb+1:2]};
        xb_nxt    = lo_q[1];
        prod_full = {hi_nxt, lo_nxt};
        sum_low   = prod_full[2*nb-1:0];
        // Bits above 2*nb only carry sign; the result wraps modulo 2^(2*nb)
        unused_prod = ^prod_full[2*nb+4:2*nb];
    end

    // FSM next-state, operand load, iteration and completion
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        xb_d      = xb_q;
        acc_en_d  = acc_en_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    mcand_d  = {{2{signed_mode & A[nb-1]}}, A};
                    hi_d     = '0;
                    lo_d     = {{2{signed_mode & B[nb-1]}}, B};
                    xb_d     = 1'b0;
                    acc_en_d = acc_en;
                end
            end
            StRun: begin
                hi_d  = hi_nxt;
                lo_d  = lo_nxt;
                xb_d  = xb_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    product_d = acc_en_q ? product_q + sum_low : sum_low;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            xb_q      <= 1'b0;
            acc_en_q  <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            xb_q      <= xb_d;
            acc_en_q  <= acc_en_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_r4_mult_acc.sv
// Randomised scoreboard bench for booth_r4_mult_acc (nb = 32).
module tb_booth_r4_mult_acc;

    localparam int NB = 32;
    localparam int N  = NB / 2 + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            signed_mode;
    logic            acc_en;
    logic [NB-1:0]   A;
    logic [NB-1:0]   B;
    logic            busy;
    logic            done;
    logic [2*NB-1:0] product;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_prod = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    booth_r4_mult_acc #(.nb(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product of the mode-extended operands, modulo 2^64
    function automatic logic [63:0] mul_ref(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one accepted start; called at a negedge while the DUT is idle
    task automatic issue(input logic s, input logic acc, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        start       = 1'b1;
        signed_mode = s;
        acc_en      = acc;
        A           = a;
        B           = b;
        ref_prod    = acc ? ref_prod + mul_ref(s, a, b) : mul_ref(s, a, b);
        e.prod      = ref_prod;
        e.due       = cyc + 1 + N;
        exp_q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        A           = $urandom;
        B           = $urandom;
        signed_mode = 1'($urandom);
        acc_en      = 1'($urandom);
        check("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < N + 4 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_done: done not seen within %0d cycles (cycle %0d)", N + 4, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done: done=1 with nothing pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e.prod);
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("busy_at_done", {63'b0, busy}, 64'd0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] edge_vals[5];
        logic [31:0] ra;
        logic [31:0] rb;
        edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner operands
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 64'd0);
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000); wait_done();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001); wait_done();

        // Back-to-back with accumulate: 12 then 42
        issue(1'b0, 1'b0, 32'd3, 32'd4); wait_done();
        check("busy_gap_low", {63'b0, busy}, 64'd0);
        issue(1'b0, 1'b1, 32'd5, 32'd6); wait_done();
        @(negedge clk);

        // Start re-pulsed mid-operation is ignored
        issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge clk);
        start = 1'b1; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; signed_mode = 1'b0; acc_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (N + 3) @(negedge clk);

        // Start held at the completion edge is ignored too
        issue(1'b0, 1'b0, 32'h0000_FFFF, 32'h0001_0001);
        repeat (N - 1) @(negedge clk);
        start = 1'b1; A = 32'h7; B = 32'h9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_after_en_start", {63'b0, busy}, 64'd0);
        repeat (N + 3) @(negedge clk);

        // Reset mid-operation aborts and clears outputs
        issue(1'b0, 1'b1, 32'hCAFE_0001, 32'h0000_0100);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        exp_q.delete();
        ref_prod = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b1, 32'd7, 32'd9); wait_done();

        // Random operands and modes, including accumulate chains
        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(7) == 0) ? edge_vals[$urandom_range(4)] : 32'($urandom);
            rb = ($urandom_range(7) == 0) ? edge_vals[$urandom_range(4)] : 32'($urandom);
            issue(1'($urandom), 1'($urandom), ra, rb);
            wait_done();
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
